// File: rtl/div_signed_ctrl.sv
// Signed/unsigned divide front end: magnitude conversion, RISC-V special cases, core handshake, sign fix-up.
// Optional macro DIV_SMALL_BYPASS_EN: skip the core when |op1| < |op2|.
module div_signed_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            ready,
  input  logic [1:0]      funct,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic            core_start,
  input  logic            core_ready,
  input  logic            core_valid,
  input  logic            core_error,
  output logic [XLEN-1:0] core_dividend,
  output logic [XLEN-1:0] core_divisor,
  input  logic [XLEN-1:0] core_quotient,
  input  logic [XLEN-1:0] core_remainder
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state;
  state_t          w_next;
  logic            r_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_dividend;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_signed;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_result;
  logic            w_bypass;
  logic [XLEN-1:0] w_bypass_result;
  logic [XLEN-1:0] w_core_q;
  logic [XLEN-1:0] w_core_r;
  logic [XLEN-1:0] w_orig_op1;
  logic [XLEN-1:0] w_wait_result;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_signed = ~funct[0];

  // Negating MIN_NEG wraps back to itself, which is already the correct unsigned magnitude.
  assign w_mag1 = (w_signed && op1[XLEN-1]) ? (XLEN'(0) - op1) : op1;
  assign w_mag2 = (w_signed && op2[XLEN-1]) ? (XLEN'(0) - op2) : op2;

  assign w_div0    = (op2 == '0);
  assign w_ovf     = w_signed && (op1 == MIN_NEG) && (op2 == ALL_ONES);
  assign w_special = w_div0 || w_ovf;

  always_comb begin
    w_special_result = '0;
    if (w_div0) begin
      w_special_result = funct[1] ? op1 : ALL_ONES;
    end else if (w_ovf) begin
      w_special_result = funct[1] ? '0 : MIN_NEG;
    end
  end

`ifdef DIV_SMALL_BYPASS_EN
  assign w_bypass = (w_mag1 < w_mag2);
`else
  assign w_bypass = 1'b0;
`endif
  assign w_bypass_result = funct[1] ? op1 : '0;

  assign w_core_q   = r_neg_q ? (XLEN'(0) - core_quotient)  : core_quotient;
  assign w_core_r   = r_neg_r ? (XLEN'(0) - core_remainder) : core_remainder;
  // The signed dividend is recoverable from its magnitude and sign flag.
  assign w_orig_op1 = r_neg_r ? (XLEN'(0) - r_dividend) : r_dividend;

  always_comb begin
    w_wait_result = r_rem ? w_core_r : w_core_q;
    if (core_error) begin
      w_wait_result = r_rem ? w_orig_op1 : ALL_ONES;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (w_special || w_bypass) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (core_ready) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_valid) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem      <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_result   <= '0;
    end else if (w_accept) begin
      r_rem      <= funct[1];
      r_neg_q    <= w_signed && (op1[XLEN-1] ^ op2[XLEN-1]);
      r_neg_r    <= w_signed && op1[XLEN-1];
      r_dividend <= w_mag1;
      r_divisor  <= w_mag2;
      if (w_special) begin
        r_result <= w_special_result;
      end else if (w_bypass) begin
        r_result <= w_bypass_result;
      end
    end else if ((r_state == S_WAIT) && core_valid) begin
      r_result <= w_wait_result;
    end
  end

  assign ready         = (r_state == S_IDLE);
  assign valid         = (r_state == S_DONE);
  assign result        = r_result;
  assign core_start    = (r_state == S_ISSUE) && core_ready;
  assign core_dividend = r_dividend;
  assign core_divisor  = r_divisor;

endmodule

// File: tb/tb_div_signed_ctrl.sv
// Directed self-checking bench for div_signed_ctrl with a small behavioural unsigned divider.
module tb_div_signed_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ready;
  logic [1:0]  funct = 2'b00;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        valid;
  logic [31:0] result;
  logic        core_start;
  logic        core_ready;
  logic        core_valid;
  logic        core_error;
  logic [31:0] core_dividend;
  logic [31:0] core_divisor;
  logic [31:0] core_quotient = '0;
  logic [31:0] core_remainder = '0;

  logic        core_en = 1'b1;
  logic        inj_valid = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_err = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  int          n_starts = 0;

  int n_chk = 0;
  int n_err = 0;

  div_signed_ctrl #(.XLEN(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .ready          (ready),
    .funct          (funct),
    .op1            (op1),
    .op2            (op2),
    .valid          (valid),
    .result         (result),
    .core_start     (core_start),
    .core_ready     (core_ready),
    .core_valid     (core_valid),
    .core_error     (core_error),
    .core_dividend  (core_dividend),
    .core_divisor   (core_divisor),
    .core_quotient  (core_quotient),
    .core_remainder (core_remainder)
  );

  always #5 clk = ~clk;

  // Behavioural iterative divider: no reset, fixed latency.
  assign core_ready = core_en && !m_busy;
  assign core_valid = m_valid || inj_valid;
  assign core_error = m_err;

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (core_start) n_starts <= n_starts + 1;
    if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy         <= 1'b0;
        m_valid        <= 1'b1;
        m_err          <= (m_b == 0);
        core_quotient  <= (m_b == 0) ? 32'hFFFF_FFFF : m_a / m_b;
        core_remainder <= (m_b == 0) ? m_a : m_a % m_b;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (core_start) begin
      m_busy <= 1'b1;
      m_cnt  <= LAT;
      m_a    <= core_dividend;
      m_b    <= core_divisor;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // kind: 0 = normal (one core issue), 1 = special case, 2 = |op1|<|op2| (core optional)
  task automatic do_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic [31:0] exp_dvd, input logic [31:0] exp_dvs, input int kind);
    int n;
    int s0;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    s0 = n_starts;
    funct = f;
    op1   = a;
    op2   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op1   = 32'hDEAD_BEEF;
    op2   = 32'h1234_5678;
    funct = ~f;
    chk({tag, "_dvd"}, core_dividend, exp_dvd);
    chk({tag, "_dvs"}, core_divisor, exp_dvs);
    n = 1;
    while (!valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    if (kind == 1) begin
      chk({tag, "_lat"}, 32'(n), 32'd1);
      chk({tag, "_nostart"}, 32'(n_starts - s0), 32'd0);
    end else if (kind == 0) begin
      chk({tag, "_starts"}, 32'(n_starts - s0), 32'd1);
    end
    chk({tag, "_res"}, result, exp_res);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int s0;
    int n;
    logic seen;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_cstart", 32'(core_start), 32'd0);
    chk("rst_dvd", core_dividend, 32'd0);
    chk("rst_dvs", core_divisor, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'd7, 32'd2, 0);
    do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'd7, 32'd2, 0);
    do_op("divu_f9_2",  2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("remu_f9_2",  2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("div_5_0",    2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 32'd0, 1);
    do_op("rem_5_0",    2'b10, 32'd5, 32'd0, 32'd5, 32'd5, 32'd0, 1);
    do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd1, 1);
    do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd1, 1);
    do_op("div_100_m7", 2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd100, 32'd7, 0);
    do_op("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'd100, 32'd7, 0);
    do_op("div_m100_m7",2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'd100, 32'd7, 0);
    do_op("rem_m100_m7",2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd100, 32'd7, 0);
    do_op("divu_min_1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 2);
    do_op("div_min_2",  2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 32'h8000_0000, 32'd2, 0);
    do_op("div_3_10",   2'b00, 32'd3, 32'd10, 32'd0, 32'd3, 32'd10, 2);
    do_op("rem_m3_10",  2'b10, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 32'd3, 32'd10, 2);

    // Core held busy: no issue until core_ready, start pulses while busy ignored.
    core_en = 1'b0;
    s0 = n_starts;
    funct = 2'b01;
    op1   = 32'd20;
    op2   = 32'd3;
    start = 1'b1;
    @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      funct = 2'b00;
      op1   = 32'd1;
      op2   = 32'd0;
      start = 1'b1;
      if (core_start || ready) seen = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    chk("hold_nostart", 32'(seen), 32'd0);
    chk("hold_count", 32'(n_starts - s0), 32'd0);
    core_en = 1'b1;
    n = 0;
    while (!valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid", 32'(valid), 32'd1);
    chk("hold_res", result, 32'd6);
    chk("hold_once", 32'(n_starts - s0), 32'd1);
    @(negedge clk);

    // Reset while waiting on the core, then stale core_valid pulses.
    funct = 2'b01;
    op1   = 32'd1000;
    op2   = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rw_in_wait", 32'(ready || valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rw_ready", 32'(ready), 32'd1);
    chk("rw_result", result, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    if (valid) seen = 1'b1;
    @(negedge clk);
    if (valid) seen = 1'b1;
    chk("rw_stale", 32'(seen), 32'd0);
    chk("rw_idle", 32'(ready), 32'd1);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd100, 32'd7, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
